// File: rtl/cla_mp_sequencer_pkg.sv
// Shared types and constants for the multi-precision CLA sequencer.
//   state_e : sequencer FSM states
//   BYTE_W  : width of the shared adder cell
//   idx_w() : width of the byte index counter for a given operand size
package cla_seq_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte index width; never narrower than one bit
  function automatic int unsigned idx_w(input int unsigned nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/cla_behavioral.sv
// 8-bit carry-lookahead adder cell (combinational).
//   sum  : a + b + cin, low 8 bits
//   cout : carry out of bit 7
//   a, b : addends
//   cin  : carry in
module cla_behavioral
  import cla_seq_pkg::*;
(
  output logic [BYTE_W-1:0] sum,
  output logic              cout,
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin
);

  logic [BYTE_W-1:0] g;
  logic [BYTE_W-1:0] p;
  logic [BYTE_W:0]   c;

  // Generate/propagate carry chain
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum  = p ^ c[BYTE_W-1:0];
    cout = c[BYTE_W];
  end

endmodule

// File: rtl/cla_mp_sequencer.sv
// Multi-precision add/subtract sequencer: runs one 8-bit CLA cell over
// NBYTES cycles, LSB first, chaining the carry through a register.
//   clk, rst_n : clock, async active-low reset
//   start      : launch request, sampled in IDLE only
//   sub        : 0 = a+b, 1 = a-b (sampled with start)
//   a, b       : W-bit operands (sampled with start)
//   busy       : high while the byte loop runs
//   done       : one-cycle pulse, result/cout/ovf valid
//   result     : W-bit sum/difference
//   cout       : final carry (sub: 1 = no borrow)
//   ovf        : signed overflow
module cla_mp_sequencer
  import cla_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  output logic                   busy,
  output logic                   done,
  output logic [BYTE_W*NBYTES-1:0] result,
  output logic                   cout,
  output logic                   ovf
);

  localparam int unsigned W     = BYTE_W * NBYTES;
  localparam int unsigned IDX_W = idx_w(NBYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [BYTE_W-1:0] a_byte_c;
  logic [BYTE_W-1:0] b_byte_c;
  logic [BYTE_W-1:0] sum_c;
  logic              cla_cout_c;

  // Current byte slice fed to the shared adder
  always_comb begin
    a_byte_c = a_q[BYTE_W*32'(idx_q) +: BYTE_W];
    b_byte_c = b_q[BYTE_W*32'(idx_q) +: BYTE_W];
  end

  cla_behavioral u_cla (
    .sum  (sum_c),
    .cout (cla_cout_c),
    .a    (a_byte_c),
    .b    (b_byte_c),
    .cin  (carry_q)
  );

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          a_d      = a;
          // Subtraction is a + ~b + 1: invert here, +1 enters as carry-in
          b_d      = sub ? ~b : b;
          carry_d  = sub;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end
      ST_RUN: begin
        result_d[BYTE_W*32'(idx_q) +: BYTE_W] = sum_c;
        carry_d = cla_cout_c;
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          idx_d   = '0;
          cout_d  = cla_cout_c;
          // b_q already holds the inverted operand for subtraction
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum_c[BYTE_W-1] != a_q[W-1]);
          done_d  = 1'b1;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          busy_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule
